layer_output_collector: RTL and testbench
=========================================

Name: layer_output_collector

Overview:
- Gathers a serial stream of neuron results, one `dataWidth` word per handshake, into a packed `numOutputs`-word vector.
- Slot layout matches what the argmax/hardmax stage consumes: slot i at bits [i*dataWidth +: dataWidth].
- Sits between the output-layer neuron sequencer (upstream, valid/ready) and the argmax stage (downstream).
- Holds a completed frame stable with `outValid` until the consumer acknowledges it, then accepts the next frame.

Parameters:
- dataWidth, 16, bit width of one neuron output word.
- numOutputs, 10, words per frame (must be ≥ 2).
- addressWidth, $clog2(numOutputs), width of the slot index / count.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- inData  input  dataWidth  incoming neuron output word.
- inValid  input  1  `inData` is valid this cycle.
- inReady  output  1  collector can accept a word this cycle.
- flush  input  1  synchronous abort of the current frame.
- outAck  input  1  consumer has taken the frame.
- dataOut  output  dataWidth*numOutputs  packed frame, slot 0 in the LSBs.
- outValid  output  1  `dataOut` holds a complete frame.
- wordCount  output  addressWidth  words accepted in the current partial frame.
- overrunErr  output  1  sticky: `inValid` was high while full for at least one cycle.

Behaviour:
- Single clock, `clk`. Reset is asynchronous, active-high, on `reset`.
- Reset values:
  - state=FILL, `wordCount`=0, `dataOut`=0, `outValid`=0, `overrunErr`=0.
  - `inReady`=0 while `reset` is asserted; `inReady`=1 from the first cycle after release.
- States: FILL and FULL. All outputs are registered or decoded from state only; no input-to-output combinational paths.
- `inReady` = (state==FILL). `outValid` = (state==FULL).
- FILL:
  - A word is accepted when `inValid` && `inReady` && !`flush`.
  - An accepted word is written to slot `wordCount`; `wordCount` increments.
  - When the accepted word is in slot numOutputs-1: go to FULL, `wordCount` wraps to 0, `outValid` is high from the next cycle.
  - Latency: last accept edge → `outValid` visible 1 cycle later, i.e. registered at that same edge.
- FULL:
  - `inReady`=0 and `dataOut` is frozen.
  - On `outAck`: go to FILL next cycle. `outValid` falls, `inReady` rises.
  - `dataOut` retains the old frame until slots are overwritten. Only `outValid` qualifies `dataOut`.
  - `inValid` while in FULL sets `overrunErr`, which is cleared only by reset. No data is lost: the upstream handshake simply stalls.
- `outAck` in FILL is ignored.
- `outAck` and `inValid` in the same FULL cycle: the ack is taken, the word is not accepted (`inReady` was 0). The word is accepted the following cycle.
- `flush`:
  - In either state: next cycle state=FILL, `wordCount`=0, `outValid`=0.
  - `dataOut` is not cleared.
  - `flush` has priority over a simultaneous `inValid` (word dropped, not accepted) and over `outAck`.
- `outValid` stays high indefinitely without `outAck`. This lets a downstream multi-cycle scan (numOutputs cycles) finish on a stable vector.
- Reset mid-frame:
  - Partial frame discarded, `dataOut` zeroed immediately (asynchronous).
  - The first word after reset lands in slot 0.
- Words are stored as raw bits; no sign or width conversion.

Test Plan:
1. Reset, then stream 10 words 0x0001..0x000A back-to-back with `inValid`=1 → `inReady` high for 10 cycles; `outValid` rises the cycle after the 10th accept; `dataOut`[15:0]=0x0001, [159:144]=0x000A; `wordCount` reads 0.
2. In FULL, hold `inValid`=1 with `inData`=0xBEEF for 3 cycles, then pulse `outAck` → `dataOut` unchanged; `overrunErr`=1; 0xBEEF is accepted into slot 0 exactly one cycle after the ack cycle; `wordCount`=1.
3. Accept 4 words, then assert `flush` together with `inValid` (`inData`=0x1234) → `wordCount`=0 next cycle; 0x1234 not stored; a new 10-word frame of 0x0100+i completes with slot 0=0x0100.
4. Insert random `inValid` gaps (e.g. valid every 3rd cycle) for a 10-word frame → exactly 10 accepts; `outValid` only after the 10th; no slot skipped or duplicated.
5. Assert `reset` asynchronously (mid-cycle) after 6 accepts → `dataOut`=0, `outValid`=0, `wordCount`=0 before the next edge; `overrunErr` cleared; the next frame starts at slot 0.
6. Connect to the argmax stage with `enable`=`outValid`, frame {3,9,0x7FFF at slot 7,…} → index 7 reported; `dataOut` remains stable until `outAck`.

Source files
------------

// File: rtl/layer_output_collector.sv
// -----------------------------------------------------------------------------
// layer_output_collector
//
// Purpose:
//   Collects a serial stream of neuron results (one dataWidth word per
//   valid/ready handshake) into a packed numOutputs-word frame for the
//   argmax/hardmax stage. Slot i lives at dataOut[i*dataWidth +: dataWidth].
//   A completed frame is held stable with outValid until outAck, after which
//   the next frame is accepted.
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   asynchronous, active-high reset
//   inData     in   incoming neuron output word (raw bits)
//   inValid    in   inData is valid this cycle
//   inReady    out  collector accepts a word this cycle (registered)
//   flush      in   synchronous abort of the current frame
//   outAck     in   consumer has taken the frame
//   dataOut    out  packed frame, slot 0 in the LSBs (registered)
//   outValid   out  dataOut holds a complete frame (decoded from state)
//   wordCount  out  words accepted in the current partial frame
//   overrunErr out  sticky: inValid seen while the frame was full
//
// numOutputs must be at least 2.
// -----------------------------------------------------------------------------
module layer_output_collector #(
  parameter int dataWidth    = 16,
  parameter int numOutputs   = 10,
  parameter int addressWidth = $clog2(numOutputs)
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [dataWidth-1:0]            inData,
  input  logic                            inValid,
  output logic                            inReady,
  input  logic                            flush,
  input  logic                            outAck,
  output logic [dataWidth*numOutputs-1:0] dataOut,
  output logic                            outValid,
  output logic [addressWidth-1:0]         wordCount,
  output logic                            overrunErr
);

  localparam logic [0:0] FILL = 1'b0;
  localparam logic [0:0] FULL = 1'b1;

  localparam logic [addressWidth-1:0] LAST_SLOT = addressWidth'(numOutputs - 1);
  localparam logic [addressWidth-1:0] ONE       = addressWidth'(1);

  logic [0:0]              state_reg;
  logic [0:0]              state_next;
  logic [addressWidth-1:0] count_reg;
  logic [addressWidth-1:0] count_next;
  logic                    in_ready_reg;
  logic                    overrun_reg;
  logic                    accept;
  logic                    last_slot;

  // in_ready_reg is only ever set while the state is FILL, so it alone
  // qualifies the handshake. It is a separate flop (rather than a decode of
  // state) so that it reads 0 throughout reset and rises after the first
  // clock edge following release.
  assign accept    = inValid && in_ready_reg && !flush;
  assign last_slot = (count_reg == LAST_SLOT);

  // ---------------------------------------------------------------------------
  // Next-state / slot-count logic. flush outranks everything else.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    if (flush) begin
      state_next = FILL;
      count_next = '0;
    end else begin
      case (state_reg)
        FILL: begin
          if (accept) begin
            if (last_slot) begin
              state_next = FULL;
              count_next = '0;
            end else begin
              count_next = count_reg + ONE;
            end
          end
        end
        FULL: begin
          // A word offered in the ack cycle is not taken; inReady rises
          // on the following cycle and upstream simply retries.
          if (outAck) begin
            state_next = FILL;
          end
        end
        default: begin
          state_next = FILL;
          count_next = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= FILL;
      count_reg    <= '0;
      in_ready_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      count_reg    <= count_next;
      in_ready_reg <= (state_next == FILL);
    end
  end

  // Sticky overrun flag: upstream pushed while the frame was waiting for the
  // consumer. Nothing is lost (inReady was low), it only flags the stall.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overrun_reg <= 1'b0;
    end else if ((state_reg == FULL) && inValid) begin
      overrun_reg <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Frame storage: one register per slot with its own write enable. Slots are
  // only zeroed by reset; flush and ack leave old contents in place, since
  // outValid is the sole qualifier of dataOut.
  // ---------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < numOutputs; gi++) begin : g_slot
      logic [dataWidth-1:0] slot_reg;
      logic                 slot_we;

      assign slot_we = accept && (count_reg == addressWidth'(gi));

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          slot_reg <= '0;
        end else if (slot_we) begin
          slot_reg <= inData;
        end
      end

      assign dataOut[gi*dataWidth +: dataWidth] = slot_reg;
    end
  endgenerate

  assign inReady    = in_ready_reg;
  assign outValid   = (state_reg == FULL);
  assign wordCount  = count_reg;
  assign overrunErr = overrun_reg;

endmodule

// File: tb/tb_layer_output_collector.sv
// -----------------------------------------------------------------------------
// tb_layer_output_collector
//
// Directed steps followed by a randomized stream, checked every cycle against
// a frame-level reference model (slot array, fill count, full flag, sticky
// overrun flag) kept in this file.
// -----------------------------------------------------------------------------
module tb_layer_output_collector;

  localparam int DW = 16;
  localparam int N  = 10;
  localparam int AW = $clog2(N);

  logic            clk = 1'b0;
  logic            reset;
  logic [DW-1:0]   inData;
  logic            inValid;
  logic            inReady;
  logic            flush;
  logic            outAck;
  logic [DW*N-1:0] dataOut;
  logic            outValid;
  logic [AW-1:0]   wordCount;
  logic            overrunErr;

  layer_output_collector #(
    .dataWidth   (DW),
    .numOutputs  (N),
    .addressWidth(AW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .inData    (inData),
    .inValid   (inValid),
    .inReady   (inReady),
    .flush     (flush),
    .outAck    (outAck),
    .dataOut   (dataOut),
    .outValid  (outValid),
    .wordCount (wordCount),
    .overrunErr(overrunErr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model
  logic [DW-1:0] m_slots [N];
  int            m_count;
  bit            m_full;
  bit            m_ovr;
  bit            m_armed;   // false until the first edge after reset release
  int            accepts;

  function automatic logic [DW*N-1:0] model_frame();
    logic [DW*N-1:0] v;
    v = '0;
    for (int k = 0; k < N; k++) v[k*DW +: DW] = m_slots[k];
    return v;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < N; k++) m_slots[k] = '0;
    m_count = 0;
    m_full  = 1'b0;
    m_ovr   = 1'b0;
    m_armed = 1'b0;
  endtask

  task automatic model_edge(input bit v, input logic [DW-1:0] d, input bit f, input bit a);
    bit rdy;
    rdy = m_armed && !m_full;
    if (m_full && v) m_ovr = 1'b1;
    if (f) begin
      m_full  = 1'b0;
      m_count = 0;
    end else if (m_full) begin
      if (a) m_full = 1'b0;
    end else if (v && rdy) begin
      m_slots[m_count] = d;
      accepts++;
      $display("t=%0t accept slot %0d data %h", $time, m_count, d);
      if (m_count == N - 1) begin
        m_count = 0;
        m_full  = 1'b1;
        $display("t=%0t frame complete %h", $time, model_frame());
      end else begin
        m_count++;
      end
    end
    m_armed = 1'b1;
  endtask

  task automatic chk(input string tag, input logic [DW*N-1:0] obs, input logic [DW*N-1:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("inReady",    (DW*N)'(inReady),    (DW*N)'(m_armed && !m_full));
    chk("outValid",   (DW*N)'(outValid),   (DW*N)'(m_full));
    chk("wordCount",  (DW*N)'(wordCount),  (DW*N)'(m_count));
    chk("overrunErr", (DW*N)'(overrunErr), (DW*N)'(m_ovr));
    chk("dataOut",    dataOut,             model_frame());
  endtask

  // One clock: drive inputs, advance model at the edge, compare 1 time unit later.
  task automatic cycle(input bit v, input logic [DW-1:0] d, input bit f, input bit a);
    inValid = v;
    inData  = d;
    flush   = f;
    outAck  = a;
    @(posedge clk);
    model_edge(v, d, f, a);
    #1;
    check_all();
  endtask

  function automatic logic [DW-1:0] slot_of(input int k);
    return dataOut[k*DW +: DW];
  endfunction

  initial begin
    int start_acc;
    int guard;
    int best;
    logic [DW-1:0] best_v;
    logic [DW*N-1:0] held;

    inValid = 1'b0;
    inData  = '0;
    flush   = 1'b0;
    outAck  = 1'b0;
    reset   = 1'b1;
    model_reset();
    #1;
    check_all();                       // reset state, inReady low during reset
    @(posedge clk);
    #3 reset = 1'b0;                   // release mid-cycle
    cycle(0, '0, 0, 0);                // inReady rises after first edge

    // Step 1: ten back-to-back words 1..10
    for (int i = 1; i <= N; i++) cycle(1, DW'(i), 0, 0);
    chk("t1_slot0", (DW*N)'(slot_of(0)), (DW*N)'(16'h0001));
    chk("t1_slot9", (DW*N)'(slot_of(9)), (DW*N)'(16'h000A));
    chk("t1_outValid", (DW*N)'(outValid), (DW*N)'(1));

    // Step 2: push while full, then ack with valid still high
    held = dataOut;
    for (int i = 0; i < 3; i++) cycle(1, 16'hBEEF, 0, 0);
    chk("t2_frozen", dataOut, held);
    chk("t2_overrun", (DW*N)'(overrunErr), (DW*N)'(1));
    cycle(1, 16'hBEEF, 0, 1);          // ack taken, word not accepted
    chk("t2_noaccept", (DW*N)'(slot_of(0)), (DW*N)'(16'h0001));
    cycle(1, 16'hBEEF, 0, 0);          // accepted now
    chk("t2_slot0", (DW*N)'(slot_of(0)), (DW*N)'(16'hBEEF));
    chk("t2_count", (DW*N)'(wordCount), (DW*N)'(1));

    // Step 3: reach 4 words, flush with a valid word, then a fresh frame
    for (int i = 1; i < 4; i++) cycle(1, DW'(16'h0050 + i), 0, 0);
    cycle(1, 16'h1234, 1, 0);
    chk("t3_count0", (DW*N)'(wordCount), (DW*N)'(0));
    chk("t3_no1234", (DW*N)'(slot_of(4)), (DW*N)'(16'h0001 + 4));
    for (int i = 0; i < N; i++) cycle(1, DW'(16'h0100 + i), 0, 0);
    chk("t3_slot0", (DW*N)'(slot_of(0)), (DW*N)'(16'h0100));
    chk("t3_slot4", (DW*N)'(slot_of(4)), (DW*N)'(16'h0104));
    cycle(0, '0, 0, 1);

    // Step 4: valid every third cycle
    start_acc = accepts;
    guard = 0;
    while (!m_full && guard < 100) begin
      cycle(guard % 3 == 0, DW'(16'h0200 + guard), 0, 0);
      guard++;
    end
    chk("t4_accepts", (DW*N)'(accepts - start_acc), (DW*N)'(N));
    chk("t4_slot9", (DW*N)'(slot_of(9)), (DW*N)'(16'h0200 + 27));
    cycle(0, '0, 0, 1);

    // Step 5: asynchronous reset after 6 accepts
    for (int i = 0; i < 6; i++) cycle(1, DW'(16'h0300 + i), 0, 0);
    #2 reset = 1'b1;
    #1;
    model_reset();
    chk("t5_data0", dataOut, '0);
    chk("t5_count0", (DW*N)'(wordCount), (DW*N)'(0));
    chk("t5_ovr0", (DW*N)'(overrunErr), (DW*N)'(0));
    check_all();
    @(posedge clk);
    #3 reset = 1'b0;
    cycle(0, '0, 0, 0);
    cycle(1, 16'h0ABC, 0, 0);
    chk("t5_slot0", (DW*N)'(slot_of(0)), (DW*N)'(16'h0ABC));
    for (int i = 1; i < N; i++) cycle(1, DW'(i), 0, 0);
    cycle(0, '0, 0, 1);

    // Step 6: argmax consumer scans a held frame for numOutputs cycles
    for (int i = 0; i < N; i++) begin
      logic [DW-1:0] w;
      w = DW'(i);
      if (i == 0) w = 16'd3;
      if (i == 1) w = 16'd9;
      if (i == 7) w = 16'h7FFF;
      cycle(1, w, 0, 0);
    end
    held = dataOut;
    for (int c = 0; c < N; c++) begin
      cycle(0, '0, 0, 0);
      best = 0;
      best_v = slot_of(0);
      for (int k = 1; k < N; k++) begin
        if (slot_of(k) > best_v) begin
          best_v = slot_of(k);
          best = k;
        end
      end
      chk("t6_argmax", (DW*N)'(best), (DW*N)'(7));
      chk("t6_stable", dataOut, held);
    end
    cycle(0, '0, 0, 1);

    // Randomized stream against the model
    for (int c = 0; c < 1500; c++) begin
      cycle(($urandom % 4) != 0, DW'($urandom), ($urandom % 60) == 0, ($urandom % 3) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
